// File: rtl/sync_fifo_flags_if.sv
// Handshake/status bundle for sync_fifo_flags: write port, show-ahead read port,
// synchronous flush, occupancy and flag outputs.
interface sync_fifo_flags_if #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
);
  logic             clear;
  logic             winc;
  logic [DSIZE-1:0] wdata;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             wfull;
  logic             rempty;
  logic             walmost_full;
  logic             ralmost_empty;
  logic [ASIZE:0]   count;
  logic             overflow;
  logic             underflow;

  // The FIFO's client drives requests and observes data/status.
  modport master (
    output clear, winc, wdata, rinc,
    input  rdata, wfull, rempty, walmost_full, ralmost_empty, count, overflow, underflow
  );

  modport slave (
    input  clear, winc, wdata, rinc,
    output rdata, wfull, rempty, walmost_full, ralmost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock show-ahead FIFO with occupancy count, programmable thresholds and flush.
// Define SYNC_FIFO_ERR_FLAGS_EN to build sticky overflow/underflow flags; otherwise they read 0.
module sync_fifo_flags #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  sync_fifo_flags_if.slave fif
);

  localparam int             DEPTH     = 1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_C   = (ASIZE + 1)'(DEPTH);
  localparam logic [ASIZE:0] AFULL_C   = (ASIZE + 1)'(AFULL_TH);
  localparam logic [ASIZE:0] AEMPTY_C  = (ASIZE + 1)'(AEMPTY_TH);

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr;
  logic [ASIZE:0]   rptr;
  logic [ASIZE:0]   count_q;
  logic [ASIZE:0]   count_d;
  logic             full;
  logic             empty;
  logic             wr_en;
  logic             rd_en;

  // Full/empty come from the count alone, so pointer wrap never creates ambiguity.
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // A flush suppresses both ports; a write while full is dropped even if a read is accepted.
  assign wr_en = fif.winc && !full  && !fif.clear;
  assign rd_en = fif.rinc && !empty && !fif.clear;

  always_comb begin
    // NOTE: default assigned first so every path drives count_d and no latch is inferred.
    count_d = count_q;
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so all updates see pre-edge values.
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else if (fif.clear) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      count_q <= count_d;
    end
  end

  // NOTE: storage has no reset; contents are only observable after a write, so it maps to plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[ASIZE-1:0]] <= fif.wdata;
  end

  // Show-ahead read: the head entry is presented combinationally.
  assign fif.rdata         = mem[rptr[ASIZE-1:0]];
  assign fif.count         = count_q;
  assign fif.wfull         = full;
  assign fif.rempty        = empty;
  assign fif.walmost_full  = (count_q >= AFULL_C);
  assign fif.ralmost_empty = (count_q <= AEMPTY_C);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf_q;
  logic udf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (fif.clear) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (fif.winc && full)  ovf_q <= 1'b1;
      if (fif.rinc && empty) udf_q <= 1'b1;
    end
  end

  assign fif.overflow  = ovf_q;
  assign fif.underflow = udf_q;
`else
  assign fif.overflow  = 1'b0;
  assign fif.underflow = 1'b0;
`endif

endmodule
